// File: rtl/sseg_arbiter.sv
// sseg_arbiter
// Four-way round-robin arbiter that shares the single 32-bit hex display
// word among independent requesters. A granted word is latched onto
// o_disp_din and held for a minimum display time before re-arbitration.
//
// Parameters:
//   DBG          "TRUE" forces an 8-cycle hold for simulation.
//   HOLD_CYCLES  hold time in clk cycles when DBG is not "TRUE" (>= 1).
//
// Ports:
//   i_clk        system clock, rising edge
//   i_resetn     synchronous active-low reset
//   i_req        request bit per requester (bit i = requester i)
//   i_req_data   requester i's word on bits [32i+31:32i]
//   o_ack        one-cycle pulse to the requester whose word was captured
//   o_disp_din   word currently displayed (to sseg.din)
//   o_grant_id   index of the requester owning o_disp_din
//   o_busy       high while the hold period runs
//   o_dbg_state  current FSM state (0 = IDLE, 1 = HOLD)
//
// Handshake: a requester raises i_req[i] with its word stable and keeps both
// until it sees o_ack[i] for one cycle; the word was captured on the edge
// that raised o_ack. Dropping i_req[i] earlier withdraws the request, and a
// request still high after o_ack counts as a fresh request.
module sseg_arbiter #(
  parameter string       DBG         = "FALSE",
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic [3:0]   i_req,
  input  logic [127:0] i_req_data,
  output logic [3:0]   o_ack,
  output logic [31:0]  o_disp_din,
  output logic [1:0]   o_grant_id,
  output logic         o_busy,
  output logic         o_dbg_state
);

  localparam logic [31:0] HOLD = (DBG == "TRUE") ? 32'd8 : 32'(HOLD_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_last, w_last_nxt;
  logic [3:0]  r_ack, w_ack_nxt;
  logic [31:0] r_disp, w_disp_nxt;
  logic [1:0]  r_gid, w_gid_nxt;
  logic        r_busy, w_busy_nxt;

  // Round-robin winner: first set request scanning r_last+1, r_last+2, ...
  // modulo 4. The 2-bit add wraps naturally; offset 4 lands on r_last itself,
  // so the previous owner wins only when nobody else is asking.
  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_idx;

  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_ack_nxt   = 4'b0000;
    w_disp_nxt  = r_disp;
    w_gid_nxt   = r_gid;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_disp_nxt       = i_req_data[32*w_win +: 32];
          w_gid_nxt        = w_win;
          w_ack_nxt[w_win] = 1'b1;
          w_last_nxt       = w_win;
          w_cnt_nxt        = 32'd0;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Requests are ignored here; the counter is cleared on every grant
        // so it cannot wrap.
        w_cnt_nxt = r_cnt + 32'd1;
        if (r_cnt == HOLD - 32'd1) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 32'd0;
      r_last  <= 2'd3;
      r_ack   <= 4'b0000;
      r_disp  <= 32'd0;
      r_gid   <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_ack   <= w_ack_nxt;
      r_disp  <= w_disp_nxt;
      r_gid   <= w_gid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_ack       = r_ack;
  assign o_disp_din  = r_disp;
  assign o_grant_id  = r_gid;
  assign o_busy      = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sseg_arbiter.sv
// Testbench for sseg_arbiter with DBG="TRUE" (8-cycle hold).
module tb_sseg_arbiter;

  localparam int HOLD = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [127:0] req_data = '0;
  logic [3:0]   ack;
  logic [31:0]  disp;
  logic [1:0]   gid;
  logic         busy;
  logic         dbg_state;

  always #5 clk = ~clk;

  sseg_arbiter #(.DBG("TRUE"), .HOLD_CYCLES(100)) dut (
    .i_clk       (clk),
    .i_resetn    (resetn),
    .i_req       (req),
    .i_req_data  (req_data),
    .o_ack       (ack),
    .o_disp_din  (disp),
    .o_grant_id  (gid),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  g_id_q[$];
  int          g_cyc_q[$];
  logic [31:0] g_dat_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks how many display cycles remain and who was granted last; a grant
  // is possible only once the remaining time has run out.
  int          m_left = 0;
  int          m_last = 3;
  logic [31:0] m_disp = '0;
  logic [1:0]  m_gid = '0;
  logic [3:0]  m_ack = '0;

  task automatic model_update();
    if (!resetn) begin
      m_left = 0; m_last = 3; m_disp = '0; m_gid = '0; m_ack = '0;
    end else begin
      m_ack = '0;
      if (m_left > 0) begin
        m_left--;
      end else if (req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int w;
          w = (m_last + k) % 4;
          if (req[w]) begin
            m_disp = req_data[32*w +: 32];
            m_gid  = 2'(w);
            m_ack  = 4'(1 << w);
            m_last = w;
            m_left = HOLD;
            break;
          end
        end
      end
    end
  endtask

  // One clock: model advances on the edge, outputs checked 1 time unit later.
  task automatic step();
    logic exp_busy;
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    exp_busy = (m_left > 0);
    chk("ack", 32'(ack), 32'(m_ack));
    chk("disp", disp, m_disp);
    chk("grant_id", 32'(gid), 32'(m_gid));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("state", 32'(dbg_state), 32'(exp_busy));
    if (ack != 4'b0000) begin
      g_id_q.push_back(gid);
      g_cyc_q.push_back(cyc);
      g_dat_q.push_back(disp);
    end
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    req = 4'b0000;
    repeat (n) step();
    resetn = 1'b1;
    g_id_q.delete(); g_cyc_q.delete(); g_dat_q.delete();
  endtask

  function automatic logic [127:0] words(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic         rstn;
    logic [3:0]   req;
    logic [127:0] data;
    logic [3:0]   e_ack;
    logic [31:0]  e_disp;
    logic [1:0]   e_gid;
    logic         e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rstn, input logic [3:0] r, input logic [127:0] d,
                         input logic [3:0] ea, input logic [31:0] ed, input logic [1:0] eg,
                         input logic eb);
    vec_t v;
    v.rstn = rstn; v.req = r; v.data = d;
    v.e_ack = ea; v.e_disp = ed; v.e_gid = eg; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  initial begin
    logic [127:0] beef;
    logic [127:0] rr;
    logic saw3;
    int n;

    beef = words(32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
    // reset held 3 cycles
    for (int i = 0; i < 3; i++) add_vec(1'b0, 4'b0000, '0, 4'b0000, 32'h0, 2'd0, 1'b0);
    // single request from requester 2
    add_vec(1'b1, 4'b0100, beef, 4'b0100, 32'hDEADBEEF, 2'd2, 1'b1);
    for (int i = 0; i < HOLD - 1; i++) add_vec(1'b1, 4'b0000, beef, 4'b0000, 32'hDEADBEEF, 2'd2, 1'b1);
    add_vec(1'b1, 4'b0000, beef, 4'b0000, 32'hDEADBEEF, 2'd2, 1'b0);
    add_vec(1'b1, 4'b0000, '0, 4'b0000, 32'hDEADBEEF, 2'd2, 1'b0);
    // reset again returns everything to zero
    add_vec(1'b0, 4'b1111, beef, 4'b0000, 32'h0, 2'd0, 1'b0);

    foreach (vecs[i]) begin
      resetn = vecs[i].rstn; req = vecs[i].req; req_data = vecs[i].data;
      step();
      chk("tbl_ack", 32'(ack), 32'(vecs[i].e_ack));
      chk("tbl_disp", disp, vecs[i].e_disp);
      chk("tbl_gid", 32'(gid), 32'(vecs[i].e_gid));
      chk("tbl_busy", 32'(busy), 32'(vecs[i].e_busy));
    end

    // ---- simultaneous requests: 0,1,2,3,0 spaced HOLD+1 apart ----
    do_reset(2);
    rr = words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    req_data = rr; req = 4'b1111;
    n = 0;
    while (g_id_q.size() < 5 && n < 80) begin step(); n++; end
    req = 4'b0000;
    chk("rr_grant_count", 32'(g_id_q.size()), 32'd5);
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    for (int i = 0; i < g_id_q.size() && i < 5; i++) begin
      chk("rr_order", 32'(g_id_q[i]), exp_q[i]);
      chk("rr_word", g_dat_q[i], 32'h11111111 * (32'(g_id_q[i]) + 32'd1));
      if (i > 0) chk("rr_spacing", 32'(g_cyc_q[i] - g_cyc_q[i-1]), 32'(HOLD + 1));
    end

    // ---- hold isolation: req[1] raised at hold cycle 3 ----
    do_reset(1);
    req_data = words(32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0, 32'h0);
    req = 4'b0001;
    step();
    chk("iso_first_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    step(); step();
    req = 4'b0010;
    n = 0;
    while (g_id_q.size() < 2 && n < 20) begin
      step(); n++;
      if (g_id_q.size() < 2) chk("iso_disp_held", disp, 32'hA0A0A0A0);
    end
    req = 4'b0000;
    chk("iso_grant_count", 32'(g_id_q.size()), 32'd2);
    if (g_id_q.size() == 2) begin
      chk("iso_second_id", 32'(g_id_q[1]), 32'd1);
      chk("iso_spacing", 32'(g_cyc_q[1] - g_cyc_q[0]), 32'(HOLD + 1));
    end

    // ---- withdrawal: requester 3 drops during hold, 0 re-granted alone ----
    do_reset(1);
    req_data = words(32'h00C0FFEE, 32'h0, 32'h0, 32'h33CC33CC);
    req = 4'b1001;
    saw3 = 1'b0;
    step();
    chk("wd_first_id", 32'(gid), 32'd0);
    req = 4'b1000;
    step(); step();
    req = 4'b0000;
    step();
    req = 4'b0001;
    n = 0;
    while (g_id_q.size() < 2 && n < 20) begin
      step(); n++;
      if (ack[3] || disp == 32'h33CC33CC) saw3 = 1'b1;
    end
    req = 4'b0000;
    chk("wd_no_req3", 32'(saw3), 32'd0);
    chk("wd_grant_count", 32'(g_id_q.size()), 32'd2);
    if (g_id_q.size() == 2) begin
      chk("wd_regrant_id", 32'(g_id_q[1]), 32'd0);
      chk("wd_spacing", 32'(g_cyc_q[1] - g_cyc_q[0]), 32'(HOLD + 1));
    end

    // ---- reset at hold cycle 4, then 4'b1010 -> requester 1 ----
    do_reset(1);
    req_data = words(32'h5A5A5A5A, 32'h1234ABCD, 32'h0, 32'h87654321);
    req = 4'b0001;
    step();
    req = 4'b0000;
    step(); step(); step();
    chk("mid_busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    step();
    chk("mid_rst_disp", disp, 32'h0);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_gid", 32'(gid), 32'h0);
    resetn = 1'b1;
    req = 4'b1010;
    step();
    chk("mid_after_gid", 32'(gid), 32'd1);
    chk("mid_after_ack", 32'(ack), 32'b0010);
    chk("mid_after_disp", disp, 32'h1234ABCD);
    req = 4'b0000;

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
      chk("ack_implies_busy", 32'((ack == 4'b0000) || busy), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
